// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats (first beat in the MSBs) into one word behind a DEPTH-entry FIFO.
// Optional macro AXIS_UPSIZER_TKEEP_EN adds the m_axis_tkeep port and per-entry lane mask storage.
module axis_upsizer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int DEPTH = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [IN_W-1:0]           s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [IN_W*RATIO-1:0]     m_axis_tdata,
`ifdef AXIS_UPSIZER_TKEEP_EN
    output logic [RATIO-1:0]          m_axis_tkeep,
`endif
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int W  = IN_W * RATIO;
    localparam int CW = $clog2(RATIO);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (IN_W < 1 || RATIO < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("axis_upsizer: illegal IN_W/RATIO/DEPTH");
    end

    logic [CW-1:0]    cnt;
    logic [W-1:0]     word_q;
    logic [W-1:0]     word_merged;
    logic [RATIO-1:0] keep_new;
    logic             accept;
    logic             complete;
    logic             push;
    logic             pop;

    logic [W-1:0]     mem_data [DEPTH];
    logic             mem_last [DEPTH];
`ifdef AXIS_UPSIZER_TKEEP_EN
    logic [RATIO-1:0] mem_keep [DEPTH];
`endif
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Ready depends only on registered occupancy, never on m_axis_tready.
    assign s_axis_tready = (fifo_level != LW'(DEPTH));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && ((cnt == CW'(RATIO - 1)) || s_axis_tlast);
    assign push          = complete;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_comb begin
        word_merged = word_q;
        word_merged[W - 1 - int'(cnt) * IN_W -: IN_W] = s_axis_tdata;
        keep_new = ~({RATIO{1'b1}} >> (int'(cnt) + 1));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt    <= '0;
            word_q <= '0;
        end else if (accept) begin
            if (complete) begin
                cnt    <= '0;
                word_q <= '0;
            end else begin
                cnt    <= cnt + 1'b1;
                word_q <= word_merged;
            end
        end
    end

    // Storage needs no reset: outputs are masked to zero whenever the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_data[wr_ptr] <= word_merged;
            mem_last[wr_ptr] <= s_axis_tlast;
`ifdef AXIS_UPSIZER_TKEEP_EN
            mem_keep[wr_ptr] <= keep_new;
`endif
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    assign m_axis_tvalid = (fifo_level != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? mem_last[rd_ptr] : 1'b0;
`ifdef AXIS_UPSIZER_TKEEP_EN
    assign m_axis_tkeep  = m_axis_tvalid ? mem_keep[rd_ptr] : '0;
`else
    logic unused_keep;
    assign unused_keep = ^keep_new;
`endif

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer: default 8->32 instance plus a 16->32 RATIO=2 DEPTH=8 instance.
module tb_axis_upsizer;

    logic        aclk = 1'b0;
    logic        aresetn;
    always #5 aclk = ~aclk;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [2:0]  level;
`ifdef AXIS_UPSIZER_TKEEP_EN
    logic [3:0]  m_tkeep;
    logic [1:0]  m_tkeep2;
`endif

    logic [15:0] s_tdata2;
    logic        s_tvalid2, s_tlast2, s_tready2;
    logic [31:0] m_tdata2;
    logic        m_tvalid2, m_tlast2, m_tready2;
    logic [3:0]  level2;

    axis_upsizer dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata),
`ifdef AXIS_UPSIZER_TKEEP_EN
        .m_axis_tkeep(m_tkeep),
`endif
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .fifo_level(level)
    );

    axis_upsizer #(.IN_W(16), .RATIO(2), .DEPTH(8)) dut2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2), .s_axis_tlast(s_tlast2),
        .s_axis_tready(s_tready2), .m_axis_tdata(m_tdata2),
`ifdef AXIS_UPSIZER_TKEEP_EN
        .m_axis_tkeep(m_tkeep2),
`endif
        .m_axis_tvalid(m_tvalid2), .m_axis_tlast(m_tlast2), .m_axis_tready(m_tready2),
        .fifo_level(level2)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } word_t;

    word_t q[$];
    int compared   = 0;
    int mismatched = 0;

    // Record each transfer on the falling edge; it completes at the following rising edge.
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
`ifdef AXIS_UPSIZER_TKEEP_EN
            q.push_back({m_tdata, m_tlast, m_tkeep});
`else
            q.push_back({m_tdata, m_tlast, 4'hF});
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        while (!s_tready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("send_timeout", 64'(n), 64'd0);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_words(input int k);
        int n;
        n = 0;
        while (q.size() < k && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("wait_timeout", 64'(q.size()), 64'(k));
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                              input logic last, input logic [3:0] keep);
        if (idx >= q.size()) begin
            check({tag, "_missing"}, 64'(q.size()), 64'(idx + 1));
        end else begin
            check({tag, "_data"}, 64'(q[idx].data), 64'(d));
            check({tag, "_last"}, 64'(q[idx].last), 64'(last));
`ifdef AXIS_UPSIZER_TKEEP_EN
            check({tag, "_keep"}, 64'(q[idx].keep), 64'(keep));
`else
            if (keep == 4'h0) check({tag, "_keep"}, 64'(q[idx].keep), 64'hF);
`endif
        end
    endtask

    initial begin
        aresetn   = 1'b0;
        s_tdata   = '0; s_tvalid  = 1'b0; s_tlast  = 1'b0; m_tready  = 1'b1;
        s_tdata2  = '0; s_tvalid2 = 1'b0; s_tlast2 = 1'b0; m_tready2 = 1'b1;
        #12;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tlast",  64'(m_tlast),  64'd0);
        check("rst_level",  64'(level),    64'd0);
`ifdef AXIS_UPSIZER_TKEEP_EN
        check("rst_tkeep",  64'(m_tkeep),  64'd0);
`endif
        aresetn = 1'b1;
        tick();
        check("rst_tready", 64'(s_tready), 64'd1);

        // Two full words, second ends the packet
        for (int i = 1; i <= 8; i++) send(8'((i << 4) | i), i == 8);
        wait_words(2);
        check_word("w11223344", 0, 32'h11223344, 1'b0, 4'b1111);
        check_word("w55667788", 1, 32'h55667788, 1'b1, 4'b1111);
        repeat (3) tick();
        check("t1_count", 64'(q.size()), 64'd2);
        q.delete();

        // Short final word: six beats
        for (int i = 1; i <= 6; i++) send(8'(8'hA0 + i), i == 6);
        wait_words(2);
        check_word("wA1A2A3A4", 0, 32'hA1A2A3A4, 1'b0, 4'b1111);
        check_word("wA5A60000", 1, 32'hA5A60000, 1'b1, 4'b1100);
        q.delete();

        // Full FIFO: 16 beats with no downstream ready, then one held beat
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        check("full_level",  64'(level),    64'd4);
        check("full_tready", 64'(s_tready), 64'd0);
        s_tdata = 8'h10; s_tlast = 1'b0; s_tvalid = 1'b1;
        repeat (3) tick();
        check("full_hold_level",  64'(level),    64'd4);
        check("full_hold_tready", 64'(s_tready), 64'd0);
        check("full_head_stable", 64'(m_tdata),  64'h00010203);
        m_tready = 1'b1;
        tick();
        check("pop_level",  64'(level),    64'd3);
        check("pop_tready", 64'(s_tready), 64'd1);
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b1);
        wait_words(5);
        check_word("drain0", 0, 32'h00010203, 1'b0, 4'b1111);
        check_word("drain1", 1, 32'h04050607, 1'b0, 4'b1111);
        check_word("drain2", 2, 32'h08090A0B, 1'b0, 4'b1111);
        check_word("drain3", 3, 32'h0C0D0E0F, 1'b0, 4'b1111);
        check_word("drain4", 4, 32'h10111213, 1'b1, 4'b1111);
        q.delete();

        // Gap mid-word must not flush
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        repeat (10) tick();
        check("gap_level",  64'(level),    64'd0);
        check("gap_tvalid", 64'(m_tvalid), 64'd0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        wait_words(1);
        repeat (3) tick();
        check("gap_count", 64'(q.size()), 64'd1);
        check_word("gap_word", 0, 32'h01020304, 1'b0, 4'b1111);
        q.delete();

        // Reset mid-operation discards queued words and the partial word
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(8'hC0 + i), 1'b0);
        for (int i = 1; i <= 4; i++) send(8'(8'hD0 + i), 1'b0);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        check("pre_rst_level", 64'(level), 64'd2);
        #2 aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_tdata",  64'(m_tdata),  64'd0);
        check("mid_rst_level",  64'(level),    64'd0);
        #2 aresetn = 1'b1;
        m_tready = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) send(8'(8'hB0 + i), 1'b0);
        wait_words(1);
        repeat (3) tick();
        check("post_rst_count", 64'(q.size()), 64'd1);
        check_word("wB1B2B3B4", 0, 32'hB1B2B3B4, 1'b0, 4'b1111);
        q.delete();

        // 16-bit lanes, RATIO=2: latency of one cycle after completing beat
        s_tdata2 = 16'h1234; s_tlast2 = 1'b0; s_tvalid2 = 1'b1;
        tick();
        check("w2_mid_tvalid", 64'(m_tvalid2), 64'd0);
        s_tdata2 = 16'h5678; s_tlast2 = 1'b1;
        tick();
        s_tvalid2 = 1'b0; s_tlast2 = 1'b0;
        check("w2_tvalid", 64'(m_tvalid2), 64'd1);
        check("w2_tdata",  64'(m_tdata2),  64'h12345678);
        check("w2_tlast",  64'(m_tlast2),  64'd1);
`ifdef AXIS_UPSIZER_TKEEP_EN
        check("w2_tkeep",  64'(m_tkeep2),  64'h3);
`endif
        tick();
        check("w2_drained", 64'(level2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

Parametrised AXI-Stream width upsizer that packs `RATIO` narrow input beats of `IN_W` bits into one `IN_W*RATIO`-bit output word. It sits between the byte-wide UDP payload path and the 32-bit (or wider) AXIS consumers. Unlike the fixed 8→32 converter, it has:

- full input backpressure (`s_axis_tready`);
- an output FIFO of `DEPTH` words;
- gap-tolerant packing;
- optional byte-lane qualification of short final words.

## Interface
- `IN_W`, default 8: input lane width in bits; ≥ 1.
- `RATIO`, default 4: input beats per output word; ≥ 2.
- `DEPTH`, default 4: output FIFO depth in words; power of two, ≥ 2.
- `aclk`  in  1  single clock; all logic on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_axis_tdata`  in  `IN_W`  input lane data.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tlast`  in  1  last beat of packet.
- `s_axis_tready`  out  1  input accept.
- `m_axis_tdata`  out  `IN_W*RATIO`  packed word.
- `m_axis_tkeep`  out  `RATIO`  lane-valid mask; present only with `AXIS_UPSIZER_TKEEP_EN`.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tlast`  out  1  output word ends packet.
- `m_axis_tready`  in  1  downstream accept.
- `fifo_level`  out  `$clog2(DEPTH)+1`  words currently held in the FIFO (0..`DEPTH`).

## Operation
- **Accepted beat:** a beat is accepted when `s_axis_tvalid && s_axis_tready`. Output word transfer is `m_axis_tvalid && m_axis_tready`.
- **Assembler:** lane counter `cnt` (0..`RATIO`-1) plus a word register.
  - Lane k (k = 0 is the first beat of a word) lands at bits `[IN_W*RATIO-1-k*IN_W -: IN_W]`, i.e. first beat in the MSBs.
- **Word completion:** an accepted beat completes a word when `cnt == RATIO-1` or `s_axis_tlast == 1`.
  - On completion, the word (with the current beat merged in), `tlast`, and keep mask are pushed to the FIFO on the same edge.
  - `cnt` returns to 0 and the word register clears to 0.
- **Non-completing beat:** the lane is stored and `cnt` increments.
- **Gaps:** `s_axis_tvalid` low mid-word is a gap only. Lanes and `cnt` are held indefinitely; the word is never flushed early.
- **Short final word:** `tlast` at `cnt = n-1` with n < `RATIO` emits a word whose lanes n..`RATIO`-1 are zero. `m_axis_tlast` = 1.
- **Keep mask:** the top n bits are set (`RATIO`=4, n=2 → 4'b1100). A full word has all ones.
- **Input backpressure:** `s_axis_tready = (fifo_level != DEPTH)`. It depends only on registered occupancy, with no combinational path from `m_axis_tready`. The rule applies to every beat, completing or not.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers.
  - `m_axis_tvalid = (fifo_level != 0)`.
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tkeep` show the head entry and stay stable while valid and not ready.
- **Simultaneous push and pop:** `fifo_level` is unchanged and both pointers advance. Pop from a full FIFO frees a slot, and `s_axis_tready` rises the next cycle.
- **Illegal parameters** (`RATIO` < 2, `DEPTH` not a power of two) are rejected at elaboration.

## Timing
- **Reset values** (asynchronous on `aresetn` low):
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `m_axis_tkeep` = 0.
  - `fifo_level` = 0, `s_axis_tready` = 1 after reset releases.
  - `cnt` = 0, pointers = 0.
- **Reset mid-operation:** the partial word and all FIFO contents are discarded, with no output on release.
- **Latency:** the beat completing a word at edge N gives `m_axis_tvalid` = 1 in the cycle after edge N, when the FIFO was empty.
- **Throughput:** one input beat per cycle sustained while `m_axis_tready` = 1. The output is valid at most 1 cycle in `RATIO`, except for short words.
- **Back-to-back packets:** a new packet's first beat may be accepted the cycle after the previous `tlast` beat. Lane 0 is used.
- **Full FIFO:** `s_axis_tready` = 0 throughout. The assembler holds its state; no beat is lost or duplicated.

## Configuration
- **`AXIS_UPSIZER_TKEEP_EN` defined:**
  - The `m_axis_tkeep` port exists and each FIFO entry stores its `RATIO`-bit mask.
  - Short words carry a partial mask as above.
- **Not defined:**
  - No `m_axis_tkeep` port and no mask storage.
  - Short words are still zero-padded with `m_axis_tlast` = 1. Consumers infer the length from packet framing.

## Test plan
- Defaults, 8 beats 0x11..0x88 (last on 0x88), `m_axis_tready`=1 → 0x11223344 (tlast 0, keep 4'b1111), then 0x55667788 (tlast 1, keep 4'b1111).
- 6 beats 0xA1..0xA6 (last on 0xA6) → 0xA1A2A3A4, then 0xA5A60000 (tlast 1, keep 4'b1100).
- `m_axis_tready`=0, continuous input → `fifo_level` reaches 4 after 16 beats and `s_axis_tready` drops. Release ready → 4 words drain in order with no loss, and `s_axis_tready` returns 1 cycle after the first pop.
- Beats 0x01, 0x02, then `s_axis_tvalid` low for 10 cycles, then 0x03, 0x04 → exactly one word 0x01020304, with no early flush.
- `aresetn` pulsed low after 2 beats with 2 words queued → outputs go to 0 immediately and `fifo_level`=0. The next 4 beats 0xB1..0xB4 yield 0xB1B2B3B4.
- `IN_W`=16, `RATIO`=2, `DEPTH`=8, beats 0x1234, 0x5678 → 0x12345678 one cycle after the second beat.
